// File: rtl/grid_image_locator.sv
// Two-stage pipelined scan-position to product-tile locator for a GRID_COLS x GRID_ROWS layout.
// Produces the image ROM address, the tile ID and a frame-synchronised, optionally blinking highlight overlay.
module grid_image_locator #(
    parameter int CNTR_WIDTH_H       = 10,
    parameter int CNTR_WIDTH_V       = 10,
    parameter int ROM_ADDR_BUS_WIDTH = 17,
    parameter int GRID_COLS          = 4,
    parameter int GRID_ROWS          = 3,
    parameter int ID_WIDTH           = 4,
    parameter int ORIGIN_X           = 308,
    parameter int ORIGIN_Y           = 20,
    parameter int PITCH_X            = 128,
    parameter int PITCH_Y            = 128,
    parameter int PIC_WIDTH          = 100,
    parameter int PIC_HEIGHT         = 100,
    parameter int IND_SIZE           = 10,
    parameter int BLINK_FRAMES       = 30,
    parameter int COLOR_WIDTH        = 24,
    parameter logic [COLOR_WIDTH-1:0] HL_COLOR = 24'h0000FF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            frame_start,
    input  logic                            pix_valid,
    input  logic [CNTR_WIDTH_H-1:0]         CounterX,
    input  logic [CNTR_WIDTH_V-1:0]         CounterY,
    input  logic [GRID_COLS*GRID_ROWS-1:0]  HighlightedProductList,
    input  logic                            blink_en,
    output logic                            out_valid,
    output logic [ROM_ADDR_BUS_WIDTH-1:0]   ROM_Addr,
    output logic                            isImage,
    output logic [ID_WIDTH-1:0]             ImageID,
    output logic                            isHighlight,
    output logic [COLOR_WIDTH-1:0]          black_white
);
    localparam int NT      = GRID_COLS * GRID_ROWS;
    localparam int CW      = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
    localparam int RW      = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
    localparam int DXW     = $clog2(PIC_WIDTH + 1);
    localparam int DYW     = $clog2(PIC_HEIGHT + 1);
    localparam int FCW     = $clog2(BLINK_FRAMES + 1);
    localparam int TILE_SZ = PIC_WIDTH * PIC_HEIGHT;

    // ---------------- stage 1: per-column / per-row window compare ----------------
    logic [31:0]    x_ext, y_ext, dx32, dy32;
    logic           col_hit, row_hit, ind_d;
    logic [CW-1:0]  col_d;
    logic [RW-1:0]  row_d;

    assign x_ext = {{(32-CNTR_WIDTH_H){1'b0}}, CounterX};
    assign y_ext = {{(32-CNTR_WIDTH_V){1'b0}}, CounterY};

    // Pitch >= picture size, so at most one window per axis can match.
    always_comb begin
        col_hit = 1'b0;
        col_d   = '0;
        dx32    = '0;
        for (int c = 0; c < GRID_COLS; c++) begin
            if (x_ext >= 32'(ORIGIN_X + c*PITCH_X) && x_ext < 32'(ORIGIN_X + c*PITCH_X + PIC_WIDTH)) begin
                col_hit = 1'b1;
                col_d   = CW'(c);
                dx32    = x_ext - 32'(ORIGIN_X + c*PITCH_X);
            end
        end
    end

    always_comb begin
        row_hit = 1'b0;
        row_d   = '0;
        dy32    = '0;
        for (int r = 0; r < GRID_ROWS; r++) begin
            if (y_ext >= 32'(ORIGIN_Y + r*PITCH_Y) && y_ext < 32'(ORIGIN_Y + r*PITCH_Y + PIC_HEIGHT)) begin
                row_hit = 1'b1;
                row_d   = RW'(r);
                dy32    = y_ext - 32'(ORIGIN_Y + r*PITCH_Y);
            end
        end
    end

    assign ind_d = (dx32 < 32'(IND_SIZE)) && (dy32 < 32'(IND_SIZE));

    logic           s1_valid_q, s1_hit_q, s1_ind_q;
    logic [CW-1:0]  s1_col_q;
    logic [RW-1:0]  s1_row_q;
    logic [DXW-1:0] s1_dx_q;
    logic [DYW-1:0] s1_dy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_hit_q   <= 1'b0;
            s1_ind_q   <= 1'b0;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
            s1_dx_q    <= '0;
            s1_dy_q    <= '0;
        end else begin
            s1_valid_q <= pix_valid;
            s1_hit_q   <= col_hit && row_hit;
            s1_ind_q   <= ind_d;
            s1_col_q   <= col_d;
            s1_row_q   <= row_d;
            s1_dx_q    <= DXW'(dx32);
            s1_dy_q    <= DYW'(dy32);
        end
    end

    // ---------------- highlight shadow and blink phase ----------------
    logic [NT-1:0]  shadow_q;
    logic           hl_any_q, phase_vis_q;
    logic [FCW-1:0] fcnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q    <= '0;
            hl_any_q    <= 1'b0;
            fcnt_q      <= '0;
            phase_vis_q <= 1'b1;
        end else begin
            if (frame_start) begin
                shadow_q <= HighlightedProductList;
                hl_any_q <= |HighlightedProductList;
            end
            if (!blink_en) begin
                fcnt_q      <= '0;
                phase_vis_q <= 1'b1;
            end else if (frame_start) begin
                if (fcnt_q == FCW'(BLINK_FRAMES - 1)) begin
                    fcnt_q      <= '0;
                    phase_vis_q <= ~phase_vis_q;
                end else begin
                    fcnt_q <= fcnt_q + 1'b1;
                end
            end
        end
    end

    // ---------------- stage 2: address, ID and colour ----------------
    logic [31:0] id32, addr32;
    logic        hl_bit;

    always_comb begin
        id32   = 32'(s1_row_q) * 32'(GRID_COLS) + 32'(s1_col_q);
        addr32 = id32 * 32'(TILE_SZ) + 32'(s1_dy_q) * 32'(PIC_WIDTH) + 32'(s1_dx_q);
        hl_bit = |(shadow_q & (NT'(1) << id32));
    end

    logic                          out_valid_q, is_image_q;
    logic [ROM_ADDR_BUS_WIDTH-1:0] rom_addr_q;
    logic [ID_WIDTH-1:0]           image_id_q;
    logic [COLOR_WIDTH-1:0]        bw_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            is_image_q  <= 1'b0;
            rom_addr_q  <= '0;
            image_id_q  <= '0;
            bw_q        <= '1;
        end else begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q && s1_hit_q) begin
                is_image_q <= 1'b1;
                rom_addr_q <= ROM_ADDR_BUS_WIDTH'(addr32);
                image_id_q <= ID_WIDTH'(id32);
                bw_q       <= (hl_bit && s1_ind_q && phase_vis_q) ? HL_COLOR : '1;
            end else begin
                is_image_q <= 1'b0;
                rom_addr_q <= '0;
                image_id_q <= '0;
                bw_q       <= '1;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign ROM_Addr    = rom_addr_q;
    assign isImage     = is_image_q;
    assign ImageID     = image_id_q;
    assign isHighlight = hl_any_q;
    assign black_white = bw_q;
endmodule

// File: tb/tb_grid_image_locator.sv
// Randomised and directed bench for grid_image_locator against a divide/modulo tile model.
module tb_grid_image_locator;
    localparam int OX = 308, OY = 20, PX = 128, PY = 128, PW = 100, PH = 100;
    localparam int COLS = 4, ROWS = 3, IND = 10, BF = 2;

    typedef struct packed {
        logic        v;
        logic [16:0] addr;
        logic        img;
        logic [3:0]  id;
        logic [23:0] bw;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [9:0]  CounterX = '0, CounterY = '0;
    logic [11:0] HighlightedProductList = '0;
    logic        blink_en = 1'b0;
    logic        out_valid, isImage, isHighlight;
    logic [16:0] ROM_Addr;
    logic [3:0]  ImageID;
    logic [23:0] black_white;

    int n_chk = 0, n_fail = 0;
    logic [11:0] m_shadow = '0;
    int m_fs = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    grid_image_locator #(.BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
        .CounterX(CounterX), .CounterY(CounterY),
        .HighlightedProductList(HighlightedProductList), .blink_en(blink_en),
        .out_valid(out_valid), .ROM_Addr(ROM_Addr), .isImage(isImage), .ImageID(ImageID),
        .isHighlight(isHighlight), .black_white(black_white)
    );

    function automatic res_t got();
        return {out_valid, ROM_Addr, isImage, ImageID, black_white};
    endfunction

    // Tile geometry via division/modulo; phase from the number of counted frames.
    function automatic res_t model(logic v, int x, int y);
        res_t r;
        int c, rr, dx, dy, id;
        r = {v, 17'd0, 1'b0, 4'd0, 24'hFFFFFF};
        if (v && x >= OX && y >= OY) begin
            c  = (x - OX) / PX;  dx = (x - OX) % PX;
            rr = (y - OY) / PY;  dy = (y - OY) % PY;
            if (c < COLS && rr < ROWS && dx < PW && dy < PH) begin
                id    = rr * COLS + c;
                r.img = 1'b1;
                r.id  = 4'(id);
                r.addr = 17'(id * PW * PH + dy * PW + dx);
                if (m_shadow[id] && dx < IND && dy < IND && ((m_fs / BF) % 2) == 0)
                    r.bw = 24'h0000FF;
            end
        end
        return r;
    endfunction

    // Drive one pixel for one cycle; returns the expectation now due at the outputs.
    task automatic px(input logic v, input int x, input int y, output logic chk, output res_t e);
        pix_valid = v;
        CounterX  = 10'(x);
        CounterY  = 10'(y);
        if (frame_start) m_shadow = HighlightedProductList;
        if (!blink_en) m_fs = 0;
        else if (frame_start) m_fs++;
        exp_q.push_back(model(v, x, y));
        @(posedge clk); #1;
        frame_start = 1'b0;
        chk = (exp_q.size() == 2);
        e = '0;
        if (chk) e = exp_q.pop_front();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (got() !== {1'b0, 17'd0, 1'b0, 4'd0, 24'hFFFFFF}) begin
            n_fail++; $display("FAIL reset_outputs got %h expected %h", got(), {1'b0, 17'd0, 1'b0, 4'd0, 24'hFFFFFF});
        end
        n_chk++;
        if (isHighlight !== 1'b0) begin n_fail++; $display("FAIL reset_isHighlight got %b expected 0", isHighlight); end
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_corners();
        int xs[$] = '{308, 307, 436, 535, 536, 791, 435, 308, 308, 407, 408, 0,   0};
        int ys[$] = '{20,  20,  148, 247, 148, 375, 148, 119, 120, 20,  20,  0,   0};
        logic chk; res_t e;
        foreach (xs[i]) begin
            px(i < xs.size() - 2, xs[i], ys[i], chk, e);
            if (chk) begin
                n_chk++;
                if (got() !== e) begin n_fail++; $display("FAIL corner_%0d got %h expected %h", i, got(), e); end
            end
        end
        px(1'b0, 0, 0, chk, e);
        if (chk) begin
            n_chk++;
            if (got() !== e) begin n_fail++; $display("FAIL corner_flush got %h expected %h", got(), e); end
        end
    endtask

    task automatic test_stream();
        logic chk; res_t e;
        for (int i = 0; i < 202; i++) begin
            px(i < 200, 300 + i, 20, chk, e);
            if (chk) begin
                n_chk++;
                if (got() !== e) begin n_fail++; $display("FAIL stream_x%0d got %h expected %h", 300 + i - 1, got(), e); end
            end
        end
    endtask

    task automatic test_highlight();
        int xs[$] = '{436, 446, 436, 445, 446, 436, 308, 308, 308, 0, 0};
        int ys[$] = '{148, 148, 148, 157, 148, 158, 20,  20,  20,  0, 0};
        logic chk; res_t e;
        HighlightedProductList = 12'h020;
        foreach (xs[i]) begin
            if (i == 2) frame_start = 1'b1;
            if (i == 6) HighlightedProductList = 12'h001;
            if (i == 7) frame_start = 1'b1;
            px(i < xs.size() - 2, xs[i], ys[i], chk, e);
            if (chk) begin
                n_chk++;
                if (got() !== e) begin n_fail++; $display("FAIL highlight_%0d got %h expected %h", i, got(), e); end
            end
            n_chk++;
            if (isHighlight !== |m_shadow) begin
                n_fail++; $display("FAIL highlight_any_%0d got %b expected %b", i, isHighlight, |m_shadow);
            end
        end
    endtask

    task automatic test_blink();
        logic chk; res_t e;
        blink_en = 1'b0;
        HighlightedProductList = 12'h001;
        frame_start = 1'b1;
        px(1'b0, 0, 0, chk, e);
        blink_en = 1'b1;
        for (int f = 0; f < 7; f++) begin
            if (f > 0) frame_start = 1'b1;
            for (int k = 0; k < 4; k++) begin
                px(1'b1, 308, 20, chk, e);
                if (chk) begin
                    n_chk++;
                    if (got() !== e) begin n_fail++; $display("FAIL blink_f%0d_%0d got %h expected %h", f, k, got(), e); end
                end
                if (k == 3) begin
                    n_chk++;
                    if (black_white !== (((f / 2) % 2 == 0) ? 24'h0000FF : 24'hFFFFFF)) begin
                        n_fail++; $display("FAIL blink_frame%0d got %h", f, black_white);
                    end
                end
            end
        end
        blink_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            px(1'b1, 308, 20, chk, e);
            if (chk) begin
                n_chk++;
                if (got() !== e) begin n_fail++; $display("FAIL blink_off_%0d got %h expected %h", k, got(), e); end
            end
        end
        n_chk++;
        if (black_white !== 24'h0000FF) begin n_fail++; $display("FAIL blink_off_red got %h expected 0000ff", black_white); end
    endtask

    task automatic test_random();
        logic chk; res_t e;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(19, 0) == 0) begin
                frame_start = 1'b1;
                HighlightedProductList = 12'($urandom);
            end
            if ($urandom_range(49, 0) == 0) blink_en = ~blink_en;
            if ($urandom_range(3, 0) == 0)
                px($urandom_range(1, 0) == 1, $urandom_range(850, 250), $urandom_range(420, 0), chk, e);
            else
                px($urandom_range(3, 0) != 0, 308 + PX * $urandom_range(3, 0) + $urandom_range(12, 0) - 1,
                   OY + PY * $urandom_range(2, 0) + $urandom_range(12, 0) - 1, chk, e);
            if (chk) begin
                n_chk++;
                if (got() !== e) begin n_fail++; $display("FAIL random_%0d got %h expected %h", i, got(), e); end
            end
            n_chk++;
            if (isHighlight !== |m_shadow) begin
                n_fail++; $display("FAIL random_any_%0d got %b expected %b", i, isHighlight, |m_shadow);
            end
        end
        blink_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic chk; res_t e;
        HighlightedProductList = 12'h001;
        frame_start = 1'b1;
        for (int i = 0; i < 6; i++) px(1'b1, 308 + i, 20, chk, e);
        rst_n = 1'b0;
        pix_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        m_shadow = '0;
        m_fs = 0;
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (got() !== {1'b0, 17'd0, 1'b0, 4'd0, 24'hFFFFFF}) begin
                n_fail++; $display("FAIL reset_mid_cycle%0d got %h expected %h", k, got(), {1'b0, 17'd0, 1'b0, 4'd0, 24'hFFFFFF});
            end
            n_chk++;
            if (isHighlight !== 1'b0) begin n_fail++; $display("FAIL reset_mid_any%0d got %b expected 0", k, isHighlight); end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++) begin
            px(i < 2, 308, 20, chk, e);
            if (chk) begin
                n_chk++;
                if (got() !== e) begin n_fail++; $display("FAIL reset_mid_shadow_%0d got %h expected %h", i, got(), e); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_corners();
        test_stream();
        test_highlight();
        test_blink();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
